// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing constants for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Iteration counter must represent 0..w-1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift / trial-subtract / restore iteration.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_divisor};

    // Partial remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
    assign o_qbit = ~w_trial[WIDTH];
    assign o_rem  = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider; DIV_SIGNED_EN builds in signed support.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q_out;
    logic [WIDTH-1:0] w_r_out;
    logic             w_last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_dsr),
        .i_bit     (r_dvd[WIDTH-1]),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    assign w_q_mag = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_r_mag = w_step_rem;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dsr_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dsr_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dsr_mag = w_dsr_neg ? -divisor : divisor;
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
    assign w_q_out   = r_neg_q ? -w_q_mag : w_q_mag;
    assign w_r_out   = r_neg_r ? -w_r_mag : w_r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_neg_q <= w_dvd_neg ^ w_dsr_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = is_signed;
    assign w_dvd_mag     = dividend;
    assign w_dsr_mag     = divisor;
    assign w_q_out       = w_q_mag;
    assign w_r_out       = w_r_mag;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (divisor == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_dsr       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_dvd <= w_dvd_mag;
                            r_dsr <= w_dsr_mag;
                            r_rem <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_dvd <= w_q_mag;
                    r_rem <= w_step_rem;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        quotient    <= w_q_out;
                        remainder   <= w_r_out;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
- REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
- REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-003 Port rst, input, 1: synchronous, active-high reset.
- REQ-004 Port start, input, 1: request a divide; accepted only in IDLE.
- REQ-005 Port is_signed, input, 1: 1 = DIV (two's complement), 0 = DIVU; sampled with start.
- REQ-006 Port dividend, input, WIDTH: numerator; sampled with start.
- REQ-007 Port divisor, input, WIDTH: denominator; sampled with start.
- REQ-008 Port busy, output, 1: high whenever state is not IDLE.
- REQ-009 Port done, output, 1: one-cycle pulse; results valid in that cycle.
- REQ-010 Port quotient, output, WIDTH: LO result, registered.
- REQ-011 Port remainder, output, WIDTH: HI result, registered.
- REQ-012 Port div_by_zero, output, 1: registered flag, valid with done.

Function
- REQ-013 FSM states SHALL be IDLE, RUN and DONE.
- REQ-014 IDLE with start=1 and divisor!=0 SHALL latch the operands, clear the iteration counter and go to RUN.
- REQ-015 IDLE with start=1 and divisor==0 SHALL go directly to DONE with quotient=all ones, remainder=dividend and div_by_zero=1.
- REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle on the operand magnitudes for exactly WIDTH cycles, then go to DONE.
- REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
- REQ-018 Latency: start accepted at edge k SHALL give done=1 in cycle k+WIDTH+1, or in cycle k+1 for divide by zero.
- REQ-019 start SHALL be ignored in RUN and DONE; in-flight operands SHALL be unaffected.
- REQ-020 Signed mode: quotient SHALL be negated if the operand signs differ, and remainder SHALL take the sign of the dividend.
- REQ-021 Signed mode: most-negative / -1 SHALL return quotient=most-negative and remainder=0 with no flag.
- REQ-022 quotient, remainder and div_by_zero SHALL hold their values from done until the next accepted start, and SHALL otherwise not change.
- REQ-023 Unsigned mode SHALL treat all WIDTH bits as magnitude, with no sign handling.

Reset
- REQ-024 When rst=1 at a clock edge: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- REQ-025 rst SHALL take priority over start, and reset mid-RUN SHALL abort the operation with no done pulse.

Configuration
- REQ-026 Macro DIV_SIGNED_EN defined: signed support per REQ-020/021 SHALL be compiled in.
- REQ-027 Macro DIV_SIGNED_EN undefined: is_signed SHALL be ignored, every operation SHALL be unsigned, and no negation logic SHALL be built.

Structure
- REQ-028 Package div_pkg SHALL hold the FSM state encoding, the DIV_WIDTH default (32) and the iteration-counter width constant.
- REQ-029 Sub-module div_step SHALL be a combinational block implementing one shift/trial-subtract/restore step: partial remainder, divisor and next dividend bit in; new partial remainder and quotient bit out.

Verification
- REQ-030 Unsigned: dividend=100, divisor=7, is_signed=0 -> done at cycle k+33, quotient=14, remainder=2.
- REQ-031 Signed: -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 -> quotient=-14, remainder=2.
- REQ-032 Divide by zero: 0x12345678 / 0 -> done at cycle k+1, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- REQ-033 Overflow: 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0, div_by_zero=0.
- REQ-034 Protocol: start pulsed at cycle 10 of RUN with new operands -> ignored; original result delivered and held; rst at cycle 5 of RUN -> IDLE, all outputs 0, no done pulse.
